// File: rtl/tmvp_job_scheduler_if.sv
// Requester, core-control, operand-address and coefficient-stream signals of tmvp_job_scheduler.
// master = requesters/core side that drives requests and core status; slave = the scheduler.
interface tmvp_job_scheduler_if #(
  parameter int N          = 512,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_WIDTH = 12
);
  localparam int AW = $clog2(N);

  logic                  req_0, req_1;
  logic [BASE_WIDTH-1:0] base_f_0, base_f_1, base_g_0, base_g_1;
  logic                  grant_0, grant_1, job_done_0, job_done_1, len_err;
  logic                  core_start, core_ready, core_done;
  logic [AW-1:0]         core_f_addr, core_g_addr;
  logic [BASE_WIDTH-1:0] bank_f_addr, bank_g_addr;
  logic [DATA_WIDTH-1:0] core_tdata, out_tdata;
  logic                  core_tvalid, out_tvalid_0, out_tvalid_1;
  logic [AW-1:0]         out_index;
  logic                  err_timeout;

  modport master (
    output req_0, req_1, base_f_0, base_f_1, base_g_0, base_g_1,
    output core_ready, core_done, core_f_addr, core_g_addr, core_tdata, core_tvalid,
    input  grant_0, grant_1, job_done_0, job_done_1, len_err, core_start,
    input  bank_f_addr, bank_g_addr, out_tdata, out_tvalid_0, out_tvalid_1, out_index, err_timeout
  );

  modport slave (
    input  req_0, req_1, base_f_0, base_f_1, base_g_0, base_g_1,
    input  core_ready, core_done, core_f_addr, core_g_addr, core_tdata, core_tvalid,
    output grant_0, grant_1, job_done_0, job_done_1, len_err, core_start,
    output bank_f_addr, bank_g_addr, out_tdata, out_tvalid_0, out_tvalid_1, out_index, err_timeout
  );
endinterface

// File: rtl/tmvp_job_scheduler.sv
// Round-robin share of one TMVP core by two requesters; bank address is combinational, out stream 1-cycle registered.
// No stall path: requests wait in IDLE for core_ready, beats are never held. TMVP_WATCHDOG_EN adds a watchdog and HALT state.
module tmvp_job_scheduler #(
  parameter int N            = 512,
  parameter int REAL_N       = 509,
  parameter int DATA_WIDTH   = 8,
  parameter int BASE_WIDTH   = 12,
  parameter int DRAIN_CYCLES = 2,
  parameter int WDOG_CYCLES  = 65535
) (
  input logic                 clk,
  input logic                 reset,
  tmvp_job_scheduler_if.slave bus
);
  localparam int AW  = $clog2(N);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0]  REAL_N_C   = AW'(REAL_N);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

`ifdef TMVP_WATCHDOG_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;
`endif

  state_t                state_q, state_d;
  logic                  owner_q, rr_last_q, win_id, take, active, drain_last, fwd, wdog_trip;
  logic [BASE_WIDTH-1:0] base_f_q, base_g_q;
  logic [AW-1:0]         beat_cnt_q, out_index_q;
  logic [DCW-1:0]        drain_cnt_q;
  logic [DATA_WIDTH-1:0] out_tdata_q;
  logic                  out_tvalid_0_q, out_tvalid_1_q;

  // On a tie the requester that did not win last time goes first.
  assign win_id     = (bus.req_0 & bus.req_1) ? ~rr_last_q : bus.req_1;
  assign active     = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fwd        = bus.core_tvalid && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign drain_last = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST) && !wdog_trip;

`ifdef TMVP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt_q;
  logic          err_q;

  assign wdog_trip = active && (wdog_cnt_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= active ? wdog_cnt_q + 1'b1 : '0;
      if (wdog_trip) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign wdog_trip       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((bus.req_0 | bus.req_1) && bus.core_ready) begin
          take    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN:   if (bus.core_done) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_IDLE;
      default: state_d = state_q;
    endcase
`ifdef TMVP_WATCHDOG_EN
    if (wdog_trip) state_d = S_HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      rr_last_q      <= 1'b1;
      base_f_q       <= '0;
      base_g_q       <= '0;
      beat_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      out_tdata_q    <= '0;
      out_index_q    <= '0;
      out_tvalid_0_q <= 1'b0;
      out_tvalid_1_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= (state_q == S_DRAIN) ? drain_cnt_q + 1'b1 : '0;
      out_tvalid_0_q <= fwd && !owner_q;
      out_tvalid_1_q <= fwd && owner_q;
      if (take) begin
        owner_q    <= win_id;
        rr_last_q  <= win_id;
        base_f_q   <= win_id ? bus.base_f_1 : bus.base_f_0;
        base_g_q   <= win_id ? bus.base_g_1 : bus.base_g_0;
        beat_cnt_q <= '0;
      end
      if (fwd) begin
        out_tdata_q <= bus.core_tdata;
        out_index_q <= beat_cnt_q;
        if (beat_cnt_q != REAL_N_C) beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (drain_last) beat_cnt_q <= '0;
    end
  end

  assign bus.grant_0      = active && !owner_q;
  assign bus.grant_1      = active && owner_q;
  assign bus.job_done_0   = drain_last && !owner_q;
  assign bus.job_done_1   = drain_last && owner_q;
  assign bus.len_err      = drain_last && (beat_cnt_q != REAL_N_C);
  assign bus.core_start   = (state_q == S_START);
  // Kept combinational so the core sees its usual BRAM read latency.
  assign bus.bank_f_addr  = base_f_q + BASE_WIDTH'(bus.core_f_addr);
  assign bus.bank_g_addr  = base_g_q + BASE_WIDTH'(bus.core_g_addr);
  assign bus.out_tdata    = out_tdata_q;
  assign bus.out_index    = out_index_q;
  assign bus.out_tvalid_0 = out_tvalid_0_q;
  assign bus.out_tvalid_1 = out_tvalid_1_q;
endmodule
